// File: rtl/es_calc_pkg.sv
// Shared definitions for the BCD calculator: key codes, operator encodings
// and the operand-capture FSM states.
package es_calc_pkg;

    localparam logic [3:0] TECLA_SUMA   = 4'hA;
    localparam logic [3:0] TECLA_RESTA  = 4'hB;
    localparam logic [3:0] TECLA_IGUAL  = 4'hC;
    localparam logic [3:0] TECLA_BORRAR = 4'hD;

    localparam logic [1:0] OP_NINGUNA = 2'b00;
    localparam logic [1:0] OP_SUMA    = 2'b10;
    localparam logic [1:0] OP_RESTA   = 2'b11;

    typedef enum logic [1:0] {
        INGRESO_1 = 2'b00,
        INGRESO_2 = 2'b01,
        MOSTRAR   = 2'b10
    } estado_t;

    // Maps an operator key to its encoding; only called with '+' or '-'.
    function automatic logic [1:0] op_de_tecla(input logic [3:0] tecla);
        return (tecla == TECLA_SUMA) ? OP_SUMA : OP_RESTA;
    endfunction

endpackage

// File: rtl/es_captura_operandos_if.sv
// Keypad-side and arithmetic-side signals of the operand-capture block.
interface es_captura_operandos_if #(parameter int N_DIGITOS = 4);

    logic                     tecla_valida;
    logic [3:0]               tecla;
    logic [4*N_DIGITOS-1:0]   numero_1;
    logic [4*N_DIGITOS-1:0]   numero_2;
    logic [1:0]               operacion;
    logic                     igual_en;
    logic [4*N_DIGITOS-1:0]   display;
    logic [1:0]               estado;

    modport master (
        output tecla_valida, tecla,
        input  numero_1, numero_2, operacion, igual_en, display, estado
    );

    modport slave (
        input  tecla_valida, tecla,
        output numero_1, numero_2, operacion, igual_en, display, estado
    );

endinterface

// File: rtl/es_registro_bcd.sv
// BCD shift-in register with digit counter. borrar and cargar may be raised
// together: the operand restarts from zero with the new digit.
module es_registro_bcd
    import es_calc_pkg::*;
#(
    parameter int N_DIGITOS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   borrar,
    input  logic                   cargar,
    input  logic [3:0]             digito,
    output logic [4*N_DIGITOS-1:0] valor,
    output logic                   lleno,
    output logic                   vacio
);

    localparam int W  = 4 * N_DIGITOS;
    localparam int CW = $clog2(N_DIGITOS + 1);

    logic [W-1:0]  valor_q,  valor_d,  base_valor_s;
    logic [CW-1:0] cuenta_q, cuenta_d, base_cuenta_s;
    logic          admite_s;

    // Next operand/count: optional clear first, then shift in one digit.
    always_comb begin
        base_valor_s  = borrar ? {W{1'b0}}  : valor_q;
        base_cuenta_s = borrar ? {CW{1'b0}} : cuenta_q;
        // A leading zero is never counted, and a full operand ignores digits.
        admite_s = cargar && (digito <= 4'd9) &&
                   (base_cuenta_s < CW'(N_DIGITOS)) &&
                   !((base_cuenta_s == {CW{1'b0}}) && (digito == 4'd0));
        if (admite_s) begin
            valor_d  = {base_valor_s[W-5:0], digito};
            cuenta_d = base_cuenta_s + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            valor_d  = base_valor_s;
            cuenta_d = base_cuenta_s;
        end
    end

    // Operand and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valor_q  <= {W{1'b0}};
            cuenta_q <= {CW{1'b0}};
        end else begin
            valor_q  <= valor_d;
            cuenta_q <= cuenta_d;
        end
    end

    assign valor = valor_q;
    assign lleno = (cuenta_q == CW'(N_DIGITOS));
    assign vacio = (cuenta_q == {CW{1'b0}});

endmodule

// File: rtl/es_captura_operandos.sv
// Keypad front end of the BCD calculator: builds two operands, latches the
// operator and holds igual_en while the arithmetic stage shows the result.
module es_captura_operandos
    import es_calc_pkg::*;
#(
    parameter int N_DIGITOS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    es_captura_operandos_if.slave bus
);

    localparam int W = 4 * N_DIGITOS;

    estado_t     estado_q, estado_d;
    logic [1:0]  operacion_q, operacion_d;
    logic        igual_en_q, igual_en_d;
    logic        borrar1_s, cargar1_s, borrar2_s, cargar2_s;
    logic        lleno1_s, vacio1_s, lleno2_s, vacio2_s;
    logic        es_digito_s, acepta1_s, acepta2_s;
    logic [W-1:0] valor1_s, valor2_s;

    es_registro_bcd #(.N_DIGITOS(N_DIGITOS)) u_operando_1 (
        .clk(clk), .reset(reset), .borrar(borrar1_s), .cargar(cargar1_s),
        .digito(bus.tecla), .valor(valor1_s), .lleno(lleno1_s), .vacio(vacio1_s)
    );

    es_registro_bcd #(.N_DIGITOS(N_DIGITOS)) u_operando_2 (
        .clk(clk), .reset(reset), .borrar(borrar2_s), .cargar(cargar2_s),
        .digito(bus.tecla), .valor(valor2_s), .lleno(lleno2_s), .vacio(vacio2_s)
    );

    assign es_digito_s = (bus.tecla <= 4'd9);
    assign acepta1_s   = es_digito_s && !lleno1_s && !(vacio1_s && (bus.tecla == 4'd0));
    assign acepta2_s   = es_digito_s && !lleno2_s && !(vacio2_s && (bus.tecla == 4'd0));

    // Next-state and register-control decode for one key strobe.
    always_comb begin
        estado_d    = estado_q;
        operacion_d = operacion_q;
        igual_en_d  = igual_en_q;
        borrar1_s   = 1'b0;
        cargar1_s   = 1'b0;
        borrar2_s   = 1'b0;
        cargar2_s   = 1'b0;
        if (!bus.tecla_valida) begin
            estado_d = estado_q;
        end else if (bus.tecla == TECLA_BORRAR) begin
            estado_d    = INGRESO_1;
            operacion_d = OP_NINGUNA;
            igual_en_d  = 1'b0;
            borrar1_s   = 1'b1;
            borrar2_s   = 1'b1;
        end else begin
            case (estado_q)
                INGRESO_1: begin
                    case (bus.tecla)
                        TECLA_SUMA, TECLA_RESTA: begin
                            operacion_d = op_de_tecla(bus.tecla);
                            estado_d    = INGRESO_2;
                            borrar2_s   = 1'b1;
                        end
                        default: cargar1_s = acepta1_s;
                    endcase
                end
                INGRESO_2: begin
                    case (bus.tecla)
                        TECLA_SUMA, TECLA_RESTA:
                            operacion_d = vacio2_s ? op_de_tecla(bus.tecla) : operacion_q;
                        TECLA_IGUAL: begin
                            igual_en_d = vacio2_s ? igual_en_q : 1'b1;
                            estado_d   = vacio2_s ? estado_q   : MOSTRAR;
                        end
                        default: cargar2_s = acepta2_s;
                    endcase
                end
                MOSTRAR: begin
                    // A new digit abandons the shown result and starts over.
                    if (es_digito_s) begin
                        estado_d    = INGRESO_1;
                        operacion_d = OP_NINGUNA;
                        igual_en_d  = 1'b0;
                        borrar1_s   = 1'b1;
                        cargar1_s   = 1'b1;
                        borrar2_s   = 1'b1;
                    end else begin
                        estado_d = estado_q;
                    end
                end
                default: begin
                    estado_d    = INGRESO_1;
                    operacion_d = OP_NINGUNA;
                    igual_en_d  = 1'b0;
                    borrar1_s   = 1'b1;
                    borrar2_s   = 1'b1;
                end
            endcase
        end
    end

    // FSM state, operator and result-enable registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= INGRESO_1;
            operacion_q <= OP_NINGUNA;
            igual_en_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            operacion_q <= operacion_d;
            igual_en_q  <= igual_en_d;
        end
    end

    assign bus.numero_1  = valor1_s;
    assign bus.numero_2  = valor2_s;
    assign bus.operacion = operacion_q;
    assign bus.igual_en  = igual_en_q;
    assign bus.estado    = estado_q;
    // Selection of already-registered values only; changes solely at clock edges.
    assign bus.display   = (estado_q == INGRESO_1) ? valor1_s :
                           (estado_q == INGRESO_2) ? (vacio2_s ? valor1_s : valor2_s) :
                           {W{1'b0}};

endmodule

// File: tb/tb_es_captura_operandos.sv
// Directed and random key sequences checked against a decimal-arithmetic model.
module tb_es_captura_operandos;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    es_captura_operandos_if #(.N_DIGITOS(4)) bus_if ();

    es_captura_operandos #(.N_DIGITOS(4)) dut (
        .clk(clk), .reset(reset), .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Model: operands as decimal integers with digit counts.
    int         m_n1, m_c1, m_n2, m_c2, m_st, m_ig;
    logic [1:0] m_op;

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_n1 = 0; m_c1 = 0; m_n2 = 0; m_c2 = 0; m_st = 0; m_ig = 0; m_op = 2'b00;
    endtask

    task automatic add1(input int d);
        if (m_c1 < 4 && !(m_c1 == 0 && d == 0)) begin m_n1 = m_n1 * 10 + d; m_c1++; end
    endtask

    task automatic add2(input int d);
        if (m_c2 < 4 && !(m_c2 == 0 && d == 0)) begin m_n2 = m_n2 * 10 + d; m_c2++; end
    endtask

    task automatic model_key(input logic [3:0] k);
        if (k == 4'hD) begin
            model_reset();
        end else if (k <= 4'd9) begin
            if (m_st == 0) add1(int'(k));
            else if (m_st == 1) add2(int'(k));
            else begin
                model_reset();
                add1(int'(k));
            end
        end else if (k == 4'hA || k == 4'hB) begin
            if (m_st == 0) begin
                m_op = (k == 4'hA) ? 2'b10 : 2'b11;
                m_st = 1; m_n2 = 0; m_c2 = 0;
            end else if (m_st == 1 && m_c2 == 0) begin
                m_op = (k == 4'hA) ? 2'b10 : 2'b11;
            end
        end else if (k == 4'hC) begin
            if (m_st == 1 && m_c2 > 0) begin m_ig = 1; m_st = 2; end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] disp_exp;
        if (m_st == 0) disp_exp = bcd(m_n1);
        else if (m_st == 1) disp_exp = (m_c2 > 0) ? bcd(m_n2) : bcd(m_n1);
        else disp_exp = 16'h0000;
        chk("numero_1",  bus_if.numero_1,            bcd(m_n1));
        chk("numero_2",  bus_if.numero_2,            bcd(m_n2));
        chk("operacion", {14'd0, bus_if.operacion},  {14'd0, m_op});
        chk("igual_en",  {15'd0, bus_if.igual_en},   16'(m_ig));
        chk("estado",    {14'd0, bus_if.estado},     16'(m_st));
        chk("display",   bus_if.display,             disp_exp);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus_if.tecla_valida = 1'b1;
        bus_if.tecla        = k;
        @(negedge clk);
        bus_if.tecla_valida = 1'b0;
        model_key(k);
        check_all();
    endtask

    task automatic idle();
        @(negedge clk);
        bus_if.tecla_valida = 1'b0;
        bus_if.tecla        = 4'($urandom_range(0, 15));
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int r;
        bus_if.tecla_valida = 1'b0;
        bus_if.tecla        = 4'h0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // 1,2,3 + 4,5 =
        press(4'h1); press(4'h2); press(4'h3); press(4'hA);
        press(4'h4); press(4'h5); press(4'hC);
        chk("plan1_n1", bus_if.numero_1, 16'h0123);
        chk("plan1_n2", bus_if.numero_2, 16'h0045);
        chk("plan1_ig", {15'd0, bus_if.igual_en}, 16'h0001);
        press(4'hA); press(4'hC);

        // 9,8,7,6,5: fifth digit dropped
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
        chk("plan2_n1", bus_if.numero_1, 16'h9876);
        chk("plan2_disp", bus_if.display, 16'h9876);

        // 0,0,7 - + 3 =
        press(4'hD);
        press(4'h0); press(4'h0); press(4'h7); press(4'hB); press(4'hA);
        press(4'h3); press(4'hC);
        chk("plan3_op", {14'd0, bus_if.operacion}, 16'h0002);
        chk("plan3_n1", bus_if.numero_1, 16'h0007);

        // digit in MOSTRAR restarts
        press(4'h5);
        chk("plan5_n1", bus_if.numero_1, 16'h0005);
        chk("plan5_st", {14'd0, bus_if.estado}, 16'h0000);

        // '=' with empty operand 2 ignored, 0 in empty operand ignored
        press(4'hD); press(4'hA); press(4'hC); press(4'h0); press(4'hC);
        chk("plan4_ig", {15'd0, bus_if.igual_en}, 16'h0000);
        press(4'hE); press(4'h2); press(4'hF); press(4'hC);
        chk("plan4_st", {14'd0, bus_if.estado}, 16'h0002);
        idle();

        // clear key mid-entry
        press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'hD);
        chk("clear_n1", bus_if.numero_1, 16'h0000);

        // asynchronous reset between edges
        press(4'h1); press(4'h2); press(4'hA); press(4'h3);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // random keys, with idle cycles carrying junk key codes
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 23));
            if (r >= 20) idle();
            else if (r < 12) press(4'(r % 10));
            else if (r < 14) press(4'hA);
            else if (r < 15) press(4'hB);
            else if (r < 17) press(4'hC);
            else if (r < 18) press(4'hD);
            else if (r < 19) press(4'hE);
            else press(4'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
